// File: rtl/seg7_time_reader_if.sv
// rtl/seg7_time_reader_if.sv - display inputs and decoded time outputs of the seven-segment time reader
interface seg7_time_reader_if;
  logic [6:0] h1;
  logic [6:0] h0;
  logic [6:0] m1;
  logic [6:0] m0;
  logic [6:0] s1;
  logic [6:0] s0;
  logic       colon;
  logic       check_en;
  logic       clear_ref;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       valid;
  logic       dec_err;
  logic       seq_err;
  logic       colon_s;

  // Drives the display and control, observes the decoded time
  modport master (
    output h1, h0, m1, m0, s1, s0, colon, check_en, clear_ref,
    input  hours, minutes, seconds, valid, dec_err, seq_err, colon_s
  );

  // The reader itself
  modport slave (
    input  h1, h0, m1, m0, s1, s0, colon, check_en, clear_ref,
    output hours, minutes, seconds, valid, dec_err, seq_err, colon_s
  );
endinterface

// File: rtl/seg7_time_reader.sv
// rtl/seg7_time_reader.sv - synchronizes, debounces and decodes a six-digit seven-segment clock display
module seg7_time_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  seg7_time_reader_if.slave bus
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  logic [41:0] r_seg_s1;
  logic [41:0] r_seg_s2;
  logic [41:0] r_prev;
  logic        r_col_s1;
  logic        r_col_s2;
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [5:0]  r_hours;
  logic [5:0]  r_minutes;
  logic [5:0]  r_seconds;
  logic [5:0]  r_ref_h;
  logic [5:0]  r_ref_m;
  logic [5:0]  r_ref_s;
  logic        r_ref_valid;
  logic        r_valid;
  logic        r_dec_err;
  logic        r_seq_err;

  logic        w_change;
  logic [4:0]  w_d_h1;
  logic [4:0]  w_d_h0;
  logic [4:0]  w_d_m1;
  logic [4:0]  w_d_m0;
  logic [4:0]  w_d_s1;
  logic [4:0]  w_d_s0;
  logic [6:0]  w_hours7;
  logic [6:0]  w_minutes7;
  logic [6:0]  w_seconds7;
  logic        w_dec_ok;
  logic [5:0]  w_inc_h;
  logic [5:0]  w_inc_m;
  logic [5:0]  w_inc_s;
  logic        w_seq_bad;

  // Returns {legal, digit}; blank is only legal where the caller allows it
  function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic blank_ok);
    case (seg)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      7'h00:   return {blank_ok, 4'd0};
      default: return 5'd0;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous display lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_col_s1 <= 1'b0;
      r_col_s2 <= 1'b0;
      r_prev   <= '0;
    end else begin
      r_seg_s1 <= {bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0};
      r_seg_s2 <= r_seg_s1;
      r_col_s1 <= bus.colon;
      r_col_s2 <= r_col_s1;
      r_prev   <= r_seg_s2;
    end
  end

  assign w_change = (r_seg_s2 != r_prev);

  // The snapshot is taken from r_prev, which is the value that has been stable
  assign w_d_h1 = seg_decode(r_prev[41:35], 1'b1);
  assign w_d_h0 = seg_decode(r_prev[34:28], 1'b0);
  assign w_d_m1 = seg_decode(r_prev[27:21], 1'b0);
  assign w_d_m0 = seg_decode(r_prev[20:14], 1'b0);
  assign w_d_s1 = seg_decode(r_prev[13:7],  1'b0);
  assign w_d_s0 = seg_decode(r_prev[6:0],   1'b0);

  // Range checks use one extra bit so 99 cannot alias into a legal 6-bit value
  assign w_hours7   = {3'b000, w_d_h1[3:0]} * 7'd10 + {3'b000, w_d_h0[3:0]};
  assign w_minutes7 = {3'b000, w_d_m1[3:0]} * 7'd10 + {3'b000, w_d_m0[3:0]};
  assign w_seconds7 = {3'b000, w_d_s1[3:0]} * 7'd10 + {3'b000, w_d_s0[3:0]};

  assign w_dec_ok = w_d_h1[4] & w_d_h0[4] & w_d_m1[4] & w_d_m0[4] & w_d_s1[4] & w_d_s0[4]
                  & (w_hours7 < 7'd24) & (w_minutes7 < 7'd60) & (w_seconds7 < 7'd60);

  // Reference time advanced by one second with full wrap-around
  always_comb begin
    w_inc_h = r_ref_h;
    w_inc_m = r_ref_m;
    w_inc_s = r_ref_s + 6'd1;
    if (r_ref_s == 6'd59) begin
      w_inc_s = 6'd0;
      w_inc_m = r_ref_m + 6'd1;
      if (r_ref_m == 6'd59) begin
        w_inc_m = 6'd0;
        w_inc_h = (r_ref_h == 6'd23) ? 6'd0 : r_ref_h + 6'd1;
      end
    end
  end

  assign w_seq_bad = bus.check_en & r_ref_valid & ~bus.clear_ref
                   & ({w_hours7[5:0], w_minutes7[5:0], w_seconds7[5:0]} != {w_inc_h, w_inc_m, w_inc_s});

  // Settle FSM: wait for a change, count quiet cycles, emit once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_WAIT;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_change) begin
            r_state <= S_SETTLE;
            r_cnt   <= 8'd0;
          end
        end
        S_SETTLE: begin
          if (w_change) begin
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt + 8'd1 == LP_STABLE) begin
              r_state <= S_EMIT;
            end
          end
        end
        S_EMIT:  r_state <= S_WAIT;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Output, error flags and sequence reference; clear_ref overrides any set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hours     <= 6'd0;
      r_minutes   <= 6'd0;
      r_seconds   <= 6'd0;
      r_ref_h     <= 6'd0;
      r_ref_m     <= 6'd0;
      r_ref_s     <= 6'd0;
      r_ref_valid <= 1'b0;
      r_valid     <= 1'b0;
      r_dec_err   <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_dec_err <= 1'b0;
      r_seq_err <= 1'b0;
      if (r_state == S_EMIT) begin
        r_valid <= 1'b1;
        if (!w_dec_ok) begin
          r_dec_err <= 1'b1;
        end else begin
          r_hours     <= w_hours7[5:0];
          r_minutes   <= w_minutes7[5:0];
          r_seconds   <= w_seconds7[5:0];
          r_seq_err   <= w_seq_bad;
          r_ref_h     <= w_hours7[5:0];
          r_ref_m     <= w_minutes7[5:0];
          r_ref_s     <= w_seconds7[5:0];
          r_ref_valid <= 1'b1;
        end
      end
      if (bus.clear_ref) begin
        r_ref_valid <= 1'b0;
      end
    end
  end

  assign bus.hours   = r_hours;
  assign bus.minutes = r_minutes;
  assign bus.seconds = r_seconds;
  assign bus.valid   = r_valid;
  assign bus.dec_err = r_dec_err;
  assign bus.seq_err = r_seq_err;
  assign bus.colon_s = r_col_s2;

endmodule

// File: tb/tb_seg7_time_reader.sv
// tb/tb_seg7_time_reader.sv - directed self-checking bench for seg7_time_reader
module tb_seg7_time_reader;

  logic clk;
  logic rst;
  seg7_time_reader_if bus();

  seg7_time_reader #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int v_cnt   = 0;
  int v_cyc   = 0;
  int v_h, v_m, v_s, v_dec, v_seq;
  int unqual  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture each valid pulse and watch for errors raised without valid
  always @(negedge clk) begin
    if (rst && bus.valid) begin
      v_cnt++;
      v_cyc = cyc;
      v_h   = int'(bus.hours);
      v_m   = int'(bus.minutes);
      v_s   = int'(bus.seconds);
      v_dec = int'(bus.dec_err);
      v_seq = int'(bus.seq_err);
    end
    if (!bus.valid && (bus.dec_err || bus.seq_err)) unqual++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clk);
    bus.h1 = enc(h / 10);
    bus.h0 = enc(h % 10);
    bus.m1 = enc(m / 10);
    bus.m0 = enc(m % 10);
    bus.s1 = enc(s / 10);
    bus.s0 = enc(s % 10);
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  int t0;
  int vb;
  int col_bad;
  logic col_hist [0:1];

  initial begin
    rst = 1'b0;
    bus.h1 = '0; bus.h0 = '0; bus.m1 = '0; bus.m0 = '0; bus.s1 = '0; bus.s0 = '0;
    bus.colon = 1'b0; bus.check_en = 1'b0; bus.clear_ref = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hours", int'(bus.hours), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_colon_s", int'(bus.colon_s), 0);
    check("rst_errs", int'({bus.dec_err, bus.seq_err}), 0);
    rst = 1'b1;
    settle();
    check("blank_no_valid", v_cnt, 0);

    // Static display and latency
    set_time(12, 34, 56);
    t0 = cyc;
    settle();
    check("static_count", v_cnt, 1);
    check("static_latency", v_cyc - (t0 + 1), 7);
    check("static_hours", v_h, 12);
    check("static_minutes", v_m, 34);
    check("static_seconds", v_s, 56);
    check("static_errs", v_dec + v_seq, 0);
    settle();
    check("static_no_repeat", v_cnt, 1);

    // Sequence check across midnight wrap
    bus.check_en = 1'b1;
    @(negedge clk); bus.clear_ref = 1'b1;
    @(negedge clk); bus.clear_ref = 1'b0;
    set_time(23, 59, 59); settle();
    check("seq_first", v_seq, 0);
    check("seq_first_hours", v_h, 23);
    set_time(0, 0, 0); settle();
    check("seq_wrap", v_seq, 0);
    check("seq_wrap_hms", v_h * 10000 + v_m * 100 + v_s, 0);
    set_time(0, 0, 2); settle();
    check("seq_skip", v_seq, 1);
    check("seq_skip_sec", v_s, 2);

    // Glitch on s0 during settle restarts the counter
    bus.check_en = 1'b0;
    vb = v_cnt;
    @(negedge clk); bus.s0 = enc(3);
    repeat (2) @(negedge clk); bus.s0 = 7'h00;
    repeat (2) @(negedge clk); bus.s0 = 7'h6F;
    t0 = cyc;
    settle();
    check("glitch_count", v_cnt - vb, 1);
    check("glitch_latency", v_cyc - (t0 + 1), 7);
    check("glitch_sec", v_s, 9);
    check("glitch_dec", v_dec, 0);

    // Illegal value holds outputs, blank tens-of-hours decodes as zero
    vb = v_cnt;
    @(negedge clk);
    bus.h1 = enc(0); bus.h0 = enc(0); bus.m1 = 7'h7D; bus.m0 = 7'h3F; bus.s1 = enc(0); bus.s0 = enc(0);
    settle();
    check("min60_count", v_cnt - vb, 1);
    check("min60_dec", v_dec, 1);
    check("min60_hold_min", v_m, 0);
    check("min60_hold_sec", v_s, 9);
    check("min60_seq", v_seq, 0);
    @(negedge clk);
    bus.h1 = 7'h00; bus.h0 = 7'h66; bus.m1 = enc(0);
    settle();
    check("blank_h1_hours", v_h, 4);
    check("blank_h1_dec", v_dec, 0);
    set_time(24, 0, 0); settle();
    check("hour24_dec", v_dec, 1);
    check("hour24_hold", v_h, 4);
    @(negedge clk); bus.m1 = 7'h00; settle();
    check("blank_m1_dec", v_dec, 1);

    // clear_ref coincident with EMIT
    bus.check_en = 1'b1;
    set_time(10, 0, 0); settle();
    check("ref_old_seq", v_seq, 1);
    set_time(10, 0, 5);
    repeat (7) @(negedge clk);
    bus.clear_ref = 1'b1;
    @(negedge clk);
    bus.clear_ref = 1'b0;
    settle();
    check("clr_emit_seq", v_seq, 0);
    check("clr_emit_sec", v_s, 5);
    set_time(10, 0, 20); settle();
    check("clr_next_seq", v_seq, 0);
    set_time(10, 0, 21); settle();
    check("rearm_ok_seq", v_seq, 0);
    set_time(10, 0, 30); settle();
    check("rearm_bad_seq", v_seq, 1);

    // Reset in the middle of settling
    vb = v_cnt;
    set_time(11, 11, 11);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_hours", int'(bus.hours), 0);
    check("midrst_no_valid", v_cnt - vb, 0);
    rst = 1'b1;
    settle();
    check("postrst_count", v_cnt - vb, 1);
    check("postrst_hours", v_h, 11);
    check("postrst_seq", v_seq, 0);

    // Colon alone: 2-cycle delay, no valid
    vb = v_cnt;
    col_bad = 0;
    col_hist[0] = bus.colon;
    col_hist[1] = bus.colon;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.colon_s !== col_hist[1]) col_bad++;
      col_hist[1] = col_hist[0];
      bus.colon = ($urandom_range(0, 2) == 0) ? bus.colon : ~bus.colon;
      col_hist[0] = bus.colon;
    end
    check("colon_follow", col_bad, 0);
    check("colon_no_valid", v_cnt - vb, 0);
    check("err_qualified", unqual, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
